// File: rtl/div_pkg.sv
// div_pkg: shared definitions for the radix-2 sequential divider.
//   XLEN        operand/result width of the divider
//   CNT_W       width of the iteration counter (counts 0..XLEN-1)
//   div_state_e control FSM states
//   negate      two's-complement negation at XLEN width
//   abs_val     magnitude of an operand; only applied when signed
package div_pkg;

    localparam int XLEN  = 32;
    localparam int CNT_W = $clog2(XLEN);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } div_state_e;

    function automatic logic [XLEN-1:0] negate(input logic [XLEN-1:0] x);
        return ~x + 1'b1;
    endfunction

    // Signed MIN maps onto itself, which the unsigned iteration reads as
    // 2^(XLEN-1) -- exactly the magnitude we need.
    function automatic logic [XLEN-1:0] abs_val(input logic [XLEN-1:0] x,
                                                input logic            is_signed);
        return (is_signed && x[XLEN-1]) ? negate(x) : x;
    endfunction

endpackage

// File: rtl/div_step.sv
// div_step: one combinational restoring-division iteration.
//   rem      in   XLEN  partial remainder (always < dvs except when dvs==0)
//   dvd      in   XLEN  dividend/quotient shift register
//   dvs      in   XLEN  divisor magnitude
//   rem_nxt  out  XLEN  partial remainder after this iteration
//   dvd_nxt  out  XLEN  shift register with the new quotient bit in the LSB
module div_step
    import div_pkg::*;
(
    input  logic [XLEN-1:0] rem,
    input  logic [XLEN-1:0] dvd,
    input  logic [XLEN-1:0] dvs,
    output logic [XLEN-1:0] rem_nxt,
    output logic [XLEN-1:0] dvd_nxt
);

    logic [XLEN:0] shifted;
    logic [XLEN:0] diff;
    logic          qbit;

    always_comb begin
        // The dividend MSB moves into the remainder while the freed LSB of
        // the dividend register collects the quotient bit.
        shifted = {rem, dvd[XLEN-1]};
        diff    = shifted - {1'b0, dvs};
        qbit    = (shifted >= {1'b0, dvs});
        rem_nxt = qbit ? diff[XLEN-1:0] : shifted[XLEN-1:0];
        dvd_nxt = {dvd[XLEN-2:0], qbit};
    end

endmodule

// File: rtl/radix2_seq_divider.sv
// radix2_seq_divider: iterative restoring divider, one quotient bit per cycle,
// serving signed/unsigned DIV and MOD for the execute stage.
//   clock                            in   1     clock
//   reset                            in   1     asynchronous, active-low reset
//   io_in_ready                      out  1     high only in IDLE
//   io_in_valid                      in   1     request, held until the response
//   io_in_bits_ctrl_flow_div_signed  in   1     operands are two's complement
//   io_in_bits_ctrl_flow_flush       in   1     abort; returns to IDLE next edge
//   io_in_bits_ctrl_data_src1        in   XLEN  dividend
//   io_in_bits_ctrl_data_src2        in   XLEN  divisor
//   io_out_ready                     in   1     consumer accepts the result
//   io_out_valid                     out  1     result valid (DONE state)
//   io_out_bits_result_quotient      out  XLEN  quotient
//   io_out_bits_result_remainder     out  XLEN  remainder
// Width comes from div_pkg::XLEN.
// Optional macro DIV_FAST_PATH_EN: divide-by-zero and |src1|<|src2| skip the
// iteration and reach DONE one edge after acceptance. Without it, every
// operation takes the full XLEN+2 latency; results are identical either way.
module radix2_seq_divider
    import div_pkg::*;
(
    input  logic            clock,
    input  logic            reset,
    output logic            io_in_ready,
    input  logic            io_in_valid,
    input  logic            io_in_bits_ctrl_flow_div_signed,
    input  logic            io_in_bits_ctrl_flow_flush,
    input  logic [XLEN-1:0] io_in_bits_ctrl_data_src1,
    input  logic [XLEN-1:0] io_in_bits_ctrl_data_src2,
    input  logic            io_out_ready,
    output logic            io_out_valid,
    output logic [XLEN-1:0] io_out_bits_result_quotient,
    output logic [XLEN-1:0] io_out_bits_result_remainder
);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(XLEN - 1);

    div_state_e       state, state_nxt;
    logic [CNT_W-1:0] count;
    logic [XLEN-1:0]  rem, dvd, dvs;
    logic [XLEN-1:0]  rem_step, dvd_step;
    logic             sign_q, sign_r, div_zero;
    logic [XLEN-1:0]  quo_out, rem_out;

    logic            flush;
    logic            accept;
    logic            fast_take;
    logic [XLEN-1:0] abs1, abs2;

    assign flush  = io_in_bits_ctrl_flow_flush;
    assign accept = (state == IDLE) && io_in_valid && !flush;
    assign abs1   = abs_val(io_in_bits_ctrl_data_src1, io_in_bits_ctrl_flow_div_signed);
    assign abs2   = abs_val(io_in_bits_ctrl_data_src2, io_in_bits_ctrl_flow_div_signed);

`ifdef DIV_FAST_PATH_EN
    // Results known without iterating: q is 0 (or all-ones for /0) and r is
    // the original dividend in both cases.
    assign fast_take = (io_in_bits_ctrl_data_src2 == '0) || (abs1 < abs2);
`else
    assign fast_take = 1'b0;
`endif

    div_step u_step (
        .rem     (rem),
        .dvd     (dvd),
        .dvs     (dvs),
        .rem_nxt (rem_step),
        .dvd_nxt (dvd_step)
    );

    // State register
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next-state logic; flush overrides everything
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: if (accept)        state_nxt = fast_take ? DONE : BUSY;
            BUSY: if (count == LAST_CNT) state_nxt = FIX;
            FIX:                     state_nxt = DONE;
            DONE: if (io_out_ready)  state_nxt = IDLE;
            default:                 state_nxt = IDLE;
        endcase
        if (flush) state_nxt = IDLE;
    end

    // Datapath. Frozen during flush so an aborted operation leaves the
    // previously delivered result untouched.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            count    <= '0;
            rem      <= '0;
            dvd      <= '0;
            dvs      <= '0;
            sign_q   <= 1'b0;
            sign_r   <= 1'b0;
            div_zero <= 1'b0;
            quo_out  <= '0;
            rem_out  <= '0;
        end else if (!flush) begin
            unique case (state)
                IDLE: begin
                    if (io_in_valid) begin
                        count    <= '0;
                        rem      <= '0;
                        dvd      <= abs1;
                        dvs      <= abs2;
                        sign_q   <= io_in_bits_ctrl_flow_div_signed &
                                    (io_in_bits_ctrl_data_src1[XLEN-1] ^
                                     io_in_bits_ctrl_data_src2[XLEN-1]);
                        sign_r   <= io_in_bits_ctrl_flow_div_signed &
                                    io_in_bits_ctrl_data_src1[XLEN-1];
                        div_zero <= (io_in_bits_ctrl_data_src2 == '0);
                        if (fast_take) begin
                            quo_out <= (io_in_bits_ctrl_data_src2 == '0) ? '1 : '0;
                            rem_out <= io_in_bits_ctrl_data_src1;
                        end
                    end
                end
                BUSY: begin
                    rem   <= rem_step;
                    dvd   <= dvd_step;
                    count <= count + CNT_W'(1);
                end
                FIX: begin
                    // With a zero divisor every iteration sets a quotient bit
                    // and the remainder accumulates |src1|; re-applying the
                    // dividend sign restores src1, only q needs forcing.
                    quo_out <= div_zero ? '1 : (sign_q ? negate(dvd) : dvd);
                    rem_out <= sign_r ? negate(rem) : rem;
                end
                DONE: ;
                default: ;
            endcase
        end
    end

    assign io_in_ready                  = (state == IDLE);
    assign io_out_valid                 = (state == DONE);
    assign io_out_bits_result_quotient  = quo_out;
    assign io_out_bits_result_remainder = rem_out;

endmodule
